// File: rtl/msk_and_sched_if.sv
// rtl/msk_and_sched_if.sv - requester, randomness and result handshakes of msk_and_sched
interface msk_and_sched_if #(
  parameter int d  = 2,
  parameter int TW = 4
);
  localparam int hpc2rnd = d * (d - 1) / 2;

  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [2*d-1:0]     req_a;
  logic [2*d-1:0]     req_b;
  logic [2*d-1:0]     req_c;
  logic [2*TW-1:0]    req_tag;
  logic               rnd_valid;
  logic               rnd_ready;
  logic [hpc2rnd-1:0] rnd_in;
  logic               res_valid;
  logic               res_ready;
  logic [d-1:0]       res_data;
  logic [TW-1:0]      res_tag;
  logic               res_src;

  modport master (
    output req_valid, req_a, req_b, req_c, req_tag, rnd_valid, rnd_in, res_ready,
    input  req_ready, rnd_ready, res_valid, res_data, res_tag, res_src
  );

  modport slave (
    input  req_valid, req_a, req_b, req_c, req_tag, rnd_valid, rnd_in, res_ready,
    output req_ready, rnd_ready, res_valid, res_data, res_tag, res_src
  );
endinterface

// File: rtl/msk_and_sched.sv
// rtl/msk_and_sched.sv - two-requester scheduler for a 2-cycle masked AND-XOR gadget
module msk_and_sched #(
  parameter int d  = 2,
  parameter int TW = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  msk_and_sched_if.slave             bus,
  output logic [d-1:0]               g_inb,
  output logic [d-1:0]               g_ina,
  output logic [d-1:0]               g_inc,
  output logic [d-1:0]               g_inb_prev,
  output logic [d*(d-1)/2-1:0]       g_rnd,
  input  logic [d-1:0]               g_out,
  output logic                       busy
);
  localparam int hpc2rnd = d * (d - 1) / 2;

  logic          s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic          s1_src_q, s1_src_d, s2_src_q, s2_src_d;
  logic [TW-1:0] s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d;
  logic [d-1:0]  s1_a_q, s1_a_d, s1_b_q, s1_b_d, s1_c_q, s1_c_d;
  logic          ptr_q, ptr_d;
  logic [1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [d-1:0]  mem_data_q [4];
  logic [d-1:0]  mem_data_d [4];
  logic [TW-1:0] mem_tag_q [4];
  logic [TW-1:0] mem_tag_d [4];
  logic          mem_src_q [4];
  logic          mem_src_d [4];

  logic          win, issue, credit, push, pop;
  logic [3:0]    total;
  logic [d-1:0]  win_a, win_b, win_c;
  logic [TW-1:0] win_tag;

  always_comb begin
    win     = (&bus.req_valid) ? ptr_q : bus.req_valid[1];
    win_a   = win ? bus.req_a[d +: d] : bus.req_a[0 +: d];
    win_b   = win ? bus.req_b[d +: d] : bus.req_b[0 +: d];
    win_c   = win ? bus.req_c[d +: d] : bus.req_c[0 +: d];
    win_tag = win ? bus.req_tag[TW +: TW] : bus.req_tag[0 +: TW];

    bus.res_valid = rst_n && (cnt_q != 3'd0);
    pop           = bus.res_valid && bus.res_ready;
    push          = s2_valid_q;
    // Every issued op holds one of four slots from issue until it is popped.
    total  = {3'b0, s1_valid_q} + {3'b0, s2_valid_q} + {1'b0, cnt_q};
    credit = (total < 4'd4) || ((total == 4'd4) && pop);
    issue  = rst_n && (|bus.req_valid) && bus.rnd_valid && credit;

    bus.req_ready = issue ? (win ? 2'b10 : 2'b01) : 2'b00;
    bus.rnd_ready = issue;
    g_inb         = issue ? win_b : '0;
    g_rnd         = issue ? bus.rnd_in : '0;
    g_ina         = (rst_n && s1_valid_q) ? s1_a_q : '0;
    g_inc         = (rst_n && s1_valid_q) ? s1_c_q : '0;
    g_inb_prev    = (rst_n && s1_valid_q) ? s1_b_q : '0;

    bus.res_data = mem_data_q[rd_ptr_q];
    bus.res_tag  = mem_tag_q[rd_ptr_q];
    bus.res_src  = mem_src_q[rd_ptr_q];
    busy         = rst_n && (s1_valid_q || s2_valid_q || (cnt_q != 3'd0));

    s1_valid_d = issue;
    s1_src_d   = win;
    s1_tag_d   = issue ? win_tag : '0;
    s1_a_d     = issue ? win_a : '0;
    s1_b_d     = issue ? win_b : '0;
    s1_c_d     = issue ? win_c : '0;
    s2_valid_d = s1_valid_q;
    s2_src_d   = s1_src_q;
    s2_tag_d   = s1_tag_q;
    ptr_d      = issue ? ~win : ptr_q;

    mem_data_d = mem_data_q;
    mem_tag_d  = mem_tag_q;
    mem_src_d  = mem_src_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push) begin
      mem_data_d[wr_ptr_q] = g_out;
      mem_tag_d[wr_ptr_q]  = s2_tag_q;
      mem_src_d[wr_ptr_q]  = s2_src_q;
      wr_ptr_d             = wr_ptr_q + 2'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
    cnt_d = cnt_q + {2'b0, push} - {2'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      ptr_q      <= 1'b0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      cnt_q      <= 3'd0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      ptr_q      <= ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
    s1_src_q   <= s1_src_d;
    s1_tag_q   <= s1_tag_d;
    s1_a_q     <= s1_a_d;
    s1_b_q     <= s1_b_d;
    s1_c_q     <= s1_c_d;
    s2_src_q   <= s2_src_d;
    s2_tag_q   <= s2_tag_d;
    mem_data_q <= mem_data_d;
    mem_tag_q  <= mem_tag_d;
    mem_src_q  <= mem_src_d;
  end

  no_push_at_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(s2_valid_q && (cnt_q == 3'd4) && !pop));
endmodule

// File: tb/tb_msk_and_sched.sv
// tb/tb_msk_and_sched.sv - randomized scoreboard bench for msk_and_sched
module tb_msk_and_sched;
  localparam int D  = 2;
  localparam int TW = 4;

  typedef struct {
    logic          bitv;
    logic [TW-1:0] tag;
    logic          src;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [D-1:0] g_inb, g_ina, g_inc, g_inb_prev, g_out;
  logic [0:0]   g_rnd;
  logic         busy;
  int checks = 0;
  int errors = 0;

  msk_and_sched_if #(.d(D), .TW(TW)) bus ();

  msk_and_sched #(.d(D), .TW(TW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .g_inb(g_inb), .g_ina(g_ina), .g_inc(g_inc), .g_inb_prev(g_inb_prev),
    .g_rnd(g_rnd), .g_out(g_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // Gadget stand-in: output sharing {r, x^r} whose XOR is a&b^c, r taken from cycle 0.
  logic       r1 = 1'b0;
  logic [1:0] gout_q = 2'b00;
  always @(posedge clk) begin
    r1     <= g_rnd[0];
    gout_q <= {r1, ((^g_ina) & (^g_inb_prev)) ^ (^g_inc) ^ r1};
  end
  assign g_out = gout_q;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  exp_t sb[$];
  int   rt[$];
  int   n = 0;
  bit   ptr = 1'b0;
  bit   p_iss = 1'b0;
  logic [D-1:0] p_a, p_b, p_c;

  // Reference model: slot accounting, round-robin pick and 3-cycle result timing.
  always @(negedge clk) begin
    n++;
    if (!rst_n) begin
      chk("rst_req_ready", 32'(bus.req_ready), 0);
      chk("rst_rnd_ready", 32'(bus.rnd_ready), 0);
      chk("rst_res_valid", 32'(bus.res_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_g_in", {26'b0, g_inb, g_ina, g_inc}, 0);
      chk("rst_g_x", {29'b0, g_inb_prev, g_rnd}, 0);
      rt.delete();
      sb.delete();
      ptr   = 1'b0;
      p_iss = 1'b0;
    end else begin
      bit   rv_exp, pop_exp, credit, iss, w;
      logic [D-1:0] a, b, c;
      rv_exp  = (rt.size() > 0) && (rt[0] <= n);
      pop_exp = rv_exp && bus.res_ready;
      credit  = (rt.size() < 4) || ((rt.size() == 4) && pop_exp);
      if (bus.req_valid == 2'b11) w = ptr;
      else w = bus.req_valid[1];
      iss = (bus.req_valid != 2'b00) && bus.rnd_valid && credit;
      a = bus.req_a[w*D +: D];
      b = bus.req_b[w*D +: D];
      c = bus.req_c[w*D +: D];
      chk("req_ready", 32'(bus.req_ready), iss ? (w ? 2 : 1) : 0);
      chk("rnd_ready", 32'(bus.rnd_ready), 32'(iss));
      chk("g_inb", 32'(g_inb), iss ? 32'(b) : 0);
      chk("g_rnd", 32'(g_rnd), iss ? 32'(bus.rnd_in) : 0);
      chk("g_ina", 32'(g_ina), p_iss ? 32'(p_a) : 0);
      chk("g_inc", 32'(g_inc), p_iss ? 32'(p_c) : 0);
      chk("g_inb_prev", 32'(g_inb_prev), p_iss ? 32'(p_b) : 0);
      chk("res_valid", 32'(bus.res_valid), 32'(rv_exp));
      chk("busy", 32'(busy), 32'(rt.size() > 0));
      if (pop_exp) void'(rt.pop_front());
      if (iss) begin
        exp_t e;
        e.bitv = ((^a) & (^b)) ^ (^c);
        e.tag  = bus.req_tag[w*TW +: TW];
        e.src  = w;
        sb.push_back(e);
        rt.push_back(n + 3);
        ptr = ~w;
      end
      p_iss = iss;
      p_a = a;
      p_b = b;
      p_c = c;
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus.res_valid && bus.res_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got tag %0h expected none", bus.res_tag);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_bit", 32'(^bus.res_data), 32'(e.bitv));
        chk("res_tag", 32'(bus.res_tag), 32'(e.tag));
        chk("res_src", 32'(bus.res_src), 32'(e.src));
      end
    end
  end

  initial begin
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.req_c = '0;
    bus.req_tag = '0; bus.rnd_valid = 1'b0; bus.rnd_in = '0; bus.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 640; k++) begin
      rst_n         = (k != 360);
      bus.req_a     = 4'($urandom);
      bus.req_b     = 4'($urandom);
      bus.req_c     = 4'($urandom);
      bus.req_tag   = 8'($urandom);
      bus.rnd_in    = 1'($urandom);
      bus.req_valid = 2'($urandom);
      bus.rnd_valid = ($urandom % 4) != 0;
      bus.res_ready = ($urandom % 3) != 0;
      if (k >= 300 && k < 346) begin
        bus.req_valid = 2'b11;
        bus.rnd_valid = !(k >= 340);
        bus.res_ready = (k >= 320);
      end else if (k >= 355 && k <= 360) begin
        bus.req_valid = 2'b11;
        bus.rnd_valid = 1'b1;
        bus.res_ready = 1'b0;
      end else if (k >= 600) begin
        bus.req_valid = 2'b00;
        bus.res_ready = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    #1;
    chk("drain_sb_empty", 32'(sb.size()), 0);
    chk("drain_busy", 32'(busy), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
